uart_rx_read_arbiter: RTL

Controller on the read side of the UART receive FIFO. It shares the single FIFO read port between NUM_REQ requesters (e.g. host bus slave, DMA engine) using round-robin arbitration. It sequences each FIFO pop as a fixed read/capture/respond transaction. It also collects the receiver's per-frame error pulses into sticky, host-clearable status plus a saturating overflow counter.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_arbiter.sv | 35 +++
 rtl/uart_rx_read_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receive-side
//                read arbiter: FSM state encoding and error-bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // One-hot read-transaction states
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_ISSUE   = 4'b0010,
      ST_CAPTURE = 4'b0100,
      ST_RESPOND = 4'b1000
   } rd_arb_state_t;

   // Bit positions inside err_status / err_clr
   localparam int ERR_OVF    = 0;
   localparam int ERR_STOP   = 1;
   localparam int ERR_PARITY = 2;
   localparam int ERR_BREAK  = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin picker. Returns the index of the
//                first set request bit at or after rr_ptr, searching
//                circularly, plus a flag telling whether any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any_req
);

   logic [IDX_W-1:0] w_idx;

   // Scan from farthest to nearest offset so the nearest set bit wins last
   always_comb begin
      gnt_idx = '0;
      w_idx   = '0;
      any_req = |req;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_idx = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (req[w_idx]) begin
            gnt_idx = w_idx;
         end
      end
   end

endmodule : uart_rr_arbiter
`default_nettype wire

// File: rtl/uart_rx_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_read_arbiter
//  Description : Shares the RX FIFO read port between NUM_REQ requesters with
//                round-robin arbitration. Each pop runs as a fixed
//                issue/capture/respond sequence. Receiver error pulses are
//                folded into sticky, host-clearable flags and a saturating
//                overflow-event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_read_arbiter
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_REQ       = 2,
   parameter int OVF_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   output logic [NUM_REQ-1:0]       rdata_valid,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     busy,
   input  logic                     fifo_empty,
   input  logic [DATA_WIDTH-1:0]    fifo_rdata,
   output logic                     fifo_read,
   input  logic                     overflow_error,
   input  logic                     stop_error,
   input  logic                     parity_error,
   input  logic                     break_error,
   input  logic [3:0]               err_clr,
   output logic [3:0]               err_status,
   output logic                     err_irq,
   output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

   localparam int c_IDX_W = $clog2(NUM_REQ);
   localparam logic [c_IDX_W-1:0]       c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
   localparam logic [c_IDX_W-1:0]       c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [OVF_CNT_WIDTH-1:0] c_OVF_ONE  = OVF_CNT_WIDTH'(1);

   rd_arb_state_t               r_state;
   rd_arb_state_t               w_state_next;
   logic [c_IDX_W-1:0]          r_gnt_idx;
   logic [c_IDX_W-1:0]          r_rr_ptr;
   logic [c_IDX_W-1:0]          w_pick_idx;
   logic                        w_any_req;
   logic                        w_grant;
   logic [DATA_WIDTH-1:0]       r_rdata;
   logic [3:0]                  r_err_status;
   logic [3:0]                  w_err_set;
   logic [OVF_CNT_WIDTH-1:0]    r_ovf_count;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_arbiter (
      .req     (req),
      .rr_ptr  (r_rr_ptr),
      .gnt_idx (w_pick_idx),
      .any_req (w_any_req)
   );

   // A grant is only taken while idle and there is a byte to pop
   assign w_grant = (r_state == ST_IDLE) && w_any_req && !fifo_empty;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and per-state strobes
   always_comb begin
      w_state_next = r_state;
      fifo_read    = 1'b0;
      rdata_valid  = '0;
      busy         = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // An empty FIFO here abandons the transaction without a pop
            if (!fifo_empty) begin
               fifo_read    = 1'b1;
               w_state_next = ST_CAPTURE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            w_state_next = ST_RESPOND;
         end
         ST_RESPOND: begin
            rdata_valid[r_gnt_idx] = 1'b1;
            w_state_next           = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Grant index, round-robin pointer and returned data register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt_idx <= '0;
         r_rr_ptr  <= '0;
         r_rdata   <= '0;
      end else begin
         if (w_grant) begin
            r_gnt_idx <= w_pick_idx;
         end
         if (r_state == ST_CAPTURE) begin
            r_rdata <= fifo_rdata;
         end
         if (r_state == ST_RESPOND) begin
            r_rr_ptr <= (r_gnt_idx == c_LAST_IDX) ? '0 : (r_gnt_idx + c_IDX_ONE);
         end
      end
   end

   always_comb begin
      w_err_set             = '0;
      w_err_set[ERR_OVF]    = overflow_error;
      w_err_set[ERR_STOP]   = stop_error;
      w_err_set[ERR_PARITY] = parity_error;
      w_err_set[ERR_BREAK]  = break_error;
   end

   // Sticky error flags; a new pulse beats a clear in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_status <= '0;
      end else begin
         r_err_status <= (r_err_status & ~err_clr) | w_err_set;
      end
   end

   // Saturating overflow counter, cleared together with the overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf_count <= '0;
      end else if (err_clr[ERR_OVF]) begin
         r_ovf_count <= overflow_error ? c_OVF_ONE : '0;
      end else if (overflow_error && (r_ovf_count != '1)) begin
         r_ovf_count <= r_ovf_count + c_OVF_ONE;
      end
   end

   assign rdata      = r_rdata;
   assign err_status = r_err_status;
   assign err_irq    = |r_err_status;
   assign ovf_count  = r_ovf_count;

endmodule : uart_rx_read_arbiter
`default_nettype wire
